// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single pipelined memory port.
// Each requester owns one request slot; a timeout aborts a stuck WAIT.
module mem_arbiter #(
   parameter int AWIDTH  = 5,
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              arb_clk,
   input  logic              arb_rst,
   input  logic              arb_i_cyc0,
   input  logic              arb_i_stb0,
   input  logic              arb_i_we0,
   input  logic              arb_i_rd0,
   input  logic [3:0]        arb_i_be0,
   input  logic [AWIDTH-1:0] arb_i_addr0,
   input  logic [DWIDTH-1:0] arb_i_wdata0,
   input  logic              arb_i_cyc1,
   input  logic              arb_i_stb1,
   input  logic              arb_i_we1,
   input  logic              arb_i_rd1,
   input  logic [3:0]        arb_i_be1,
   input  logic [AWIDTH-1:0] arb_i_addr1,
   input  logic [DWIDTH-1:0] arb_i_wdata1,
   output logic [DWIDTH-1:0] arb_o_rdata0,
   output logic              arb_o_ack0,
   output logic              arb_o_stall0,
   output logic [DWIDTH-1:0] arb_o_rdata1,
   output logic              arb_o_ack1,
   output logic              arb_o_stall1,
   input  logic              arb_i_flush0,
   output logic              arb_o_cyc,
   output logic              arb_o_stb,
   output logic              arb_o_we,
   output logic              arb_o_rd,
   output logic [3:0]        arb_o_be,
   output logic [AWIDTH-1:0] arb_o_load_addr,
   output logic [AWIDTH-1:0] arb_o_store_addr,
   output logic [DWIDTH-1:0] arb_o_wdata,
   input  logic [DWIDTH-1:0] arb_i_rdata,
   input  logic              arb_i_ack,
   input  logic              arb_i_stall,
   output logic              arb_o_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   logic [1:0]              in_cyc, in_stb, in_we, in_rd;
   logic [1:0][3:0]         in_be;
   logic [1:0][AWIDTH-1:0]  in_addr;
   logic [1:0][DWIDTH-1:0]  in_wdata;

   assign in_cyc   = {arb_i_cyc1, arb_i_cyc0};
   assign in_stb   = {arb_i_stb1, arb_i_stb0};
   assign in_we    = {arb_i_we1, arb_i_we0};
   assign in_rd    = {arb_i_rd1, arb_i_rd0};
   assign in_be    = {arb_i_be1, arb_i_be0};
   assign in_addr  = {arb_i_addr1, arb_i_addr0};
   assign in_wdata = {arb_i_wdata1, arb_i_wdata0};

   state_t                  state_q, state_d;
   logic                    owner_q, owner_d;
   logic                    last_grant_q, last_grant_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    flush_own0_q, flush_own0_d;
   logic [1:0]              slot_valid_q, slot_valid_d;
   logic [1:0]              slot_st_q, slot_st_d;
   logic [1:0][3:0]         slot_be_q, slot_be_d;
   logic [1:0][AWIDTH-1:0]  slot_addr_q, slot_addr_d;
   logic [1:0][DWIDTH-1:0]  slot_wdata_q, slot_wdata_d;
   logic [1:0][DWIDTH-1:0]  rdata_q, rdata_d;
   logic [1:0]              ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    o_cyc_q, o_cyc_d, o_stb_q, o_stb_d;
   logic                    o_we_q, o_we_d, o_rd_q, o_rd_d;
   logic [3:0]              o_be_q, o_be_d;
   logic [AWIDTH-1:0]       o_laddr_q, o_laddr_d, o_saddr_q, o_saddr_d;
   logic [DWIDTH-1:0]       o_wdata_q, o_wdata_d;

   logic                    grant, done, timed_out, owned0;
   logic [1:0]              vld;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      flush_own0_d = flush_own0_q;
      slot_valid_d = slot_valid_q;
      slot_st_d    = slot_st_q;
      slot_be_d    = slot_be_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      rdata_d      = rdata_q;
      ack_d        = '0;
      err_d        = 1'b0;
      o_cyc_d      = o_cyc_q;
      o_stb_d      = o_stb_q;
      o_we_d       = o_we_q;
      o_rd_d       = o_rd_q;
      o_be_d       = o_be_q;
      o_laddr_d    = o_laddr_q;
      o_saddr_d    = o_saddr_q;
      o_wdata_d    = o_wdata_q;
      grant        = 1'b0;
      done         = 1'b0;
      timed_out    = 1'b0;
      owned0       = (state_q != IDLE) && (owner_q == 1'b0);
      vld          = slot_valid_q;

      // An unowned port-0 slot is dropped outright; an owned one finishes silently.
      if (arb_i_flush0 && !owned0) begin
         vld[0]          = 1'b0;
         slot_valid_d[0] = 1'b0;
      end
      if (arb_i_flush0 && owned0)
         flush_own0_d = 1'b1;

      for (int p = 0; p < 2; p++) begin
         if (!slot_valid_q[p] && in_cyc[p] && in_stb[p] && !(p == 0 && arb_i_flush0)) begin
            slot_valid_d[p] = 1'b1;
            case ({in_we[p], in_rd[p]})
               2'b10, 2'b11: slot_st_d[p] = 1'b1;
               default:      slot_st_d[p] = 1'b0;
            endcase
            slot_be_d[p]    = in_be[p];
            slot_addr_d[p]  = in_addr[p];
            slot_wdata_d[p] = in_wdata[p];
         end
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (vld != 2'b00) begin
               grant     = (vld == 2'b11) ? ~last_grant_q : vld[1];
               owner_d   = grant;
               state_d   = ISSUE;
               o_cyc_d   = 1'b1;
               o_stb_d   = 1'b1;
               o_we_d    = slot_st_q[grant];
               o_rd_d    = ~slot_st_q[grant];
               o_be_d    = slot_be_q[grant];
               o_wdata_d = slot_wdata_q[grant];
               o_laddr_d = slot_st_q[grant] ? '0 : slot_addr_q[grant];
               o_saddr_d = slot_st_q[grant] ? slot_addr_q[grant] : '0;
            end
         end
         ISSUE: begin
            if (arb_i_ack) begin
               done = 1'b1;
            end else if (!arb_i_stall) begin
               state_d   = WAIT;
               o_stb_d   = 1'b0;
               o_we_d    = 1'b0;
               o_rd_d    = 1'b0;
               o_be_d    = '0;
               o_laddr_d = '0;
               o_saddr_d = '0;
               o_wdata_d = '0;
            end
         end
         WAIT: begin
            if (arb_i_ack) begin
               done = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               done      = 1'b1;
               timed_out = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         state_d               = IDLE;
         cnt_d                 = '0;
         last_grant_d          = owner_q;
         slot_valid_d[owner_q] = 1'b0;
         flush_own0_d          = 1'b0;
         err_d                 = timed_out;
         o_cyc_d               = 1'b0;
         o_stb_d               = 1'b0;
         o_we_d                = 1'b0;
         o_rd_d                = 1'b0;
         o_be_d                = '0;
         o_laddr_d             = '0;
         o_saddr_d             = '0;
         o_wdata_d             = '0;
         if (!(owner_q == 1'b0 && (flush_own0_q || arb_i_flush0))) begin
            ack_d[owner_q]   = 1'b1;
            rdata_d[owner_q] = timed_out ? '0 : arb_i_rdata;
         end
      end
   end

   always_ff @(posedge arb_clk or negedge arb_rst) begin
      if (!arb_rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         flush_own0_q <= 1'b0;
         slot_valid_q <= '0;
         slot_st_q    <= '0;
         slot_be_q    <= '0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         rdata_q      <= '0;
         ack_q        <= '0;
         err_q        <= 1'b0;
         o_cyc_q      <= 1'b0;
         o_stb_q      <= 1'b0;
         o_we_q       <= 1'b0;
         o_rd_q       <= 1'b0;
         o_be_q       <= '0;
         o_laddr_q    <= '0;
         o_saddr_q    <= '0;
         o_wdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         flush_own0_q <= flush_own0_d;
         slot_valid_q <= slot_valid_d;
         slot_st_q    <= slot_st_d;
         slot_be_q    <= slot_be_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         o_cyc_q      <= o_cyc_d;
         o_stb_q      <= o_stb_d;
         o_we_q       <= o_we_d;
         o_rd_q       <= o_rd_d;
         o_be_q       <= o_be_d;
         o_laddr_q    <= o_laddr_d;
         o_saddr_q    <= o_saddr_d;
         o_wdata_q    <= o_wdata_d;
      end
   end

   assign arb_o_rdata0     = rdata_q[0];
   assign arb_o_rdata1     = rdata_q[1];
   assign arb_o_ack0       = ack_q[0];
   assign arb_o_ack1       = ack_q[1];
   assign arb_o_stall0     = slot_valid_q[0];
   assign arb_o_stall1     = slot_valid_q[1];
   assign arb_o_err        = err_q;
   assign arb_o_cyc        = o_cyc_q;
   assign arb_o_stb        = o_stb_q;
   assign arb_o_we         = o_we_q;
   assign arb_o_rd         = o_rd_q;
   assign arb_o_be         = o_be_q;
   assign arb_o_load_addr  = o_laddr_q;
   assign arb_o_store_addr = o_saddr_q;
   assign arb_o_wdata      = o_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AWIDTH, default 5, word address width; DWIDTH, default 32, data width; TIMEOUT, default 16, maximum WAIT cycles before abort.
REQ-002 SHALL have ports: arb_clk in 1, single clock, all logic rising-edge.
REQ-003 SHALL have ports: arb_rst in 1, reset, asynchronous and active-low.
REQ-004 SHALL have, per requester p in {0,1}, input ports: arb_i_cyc{p} in 1 bus cycle; arb_i_stb{p} in 1 one-cycle request strobe; arb_i_we{p} in 1 store; arb_i_rd{p} in 1 load; arb_i_be{p} in 4 byte enables; arb_i_addr{p} in AWIDTH word address; arb_i_wdata{p} in DWIDTH store data.
REQ-005 SHALL have, per requester p, output ports: arb_o_rdata{p} out DWIDTH load data; arb_o_ack{p} out 1 completion pulse; arb_o_stall{p} out 1 slot busy.
REQ-006 SHALL have input port arb_i_flush0 in 1: drop requester 0's pending request.
REQ-007 SHALL have memory-side output ports: arb_o_cyc, arb_o_stb, arb_o_we, arb_o_rd, all out 1; arb_o_be out 4; arb_o_load_addr out AWIDTH; arb_o_store_addr out AWIDTH; arb_o_wdata out DWIDTH.
REQ-008 SHALL have memory-side input ports: arb_i_rdata in DWIDTH; arb_i_ack in 1; arb_i_stall in 1.
REQ-009 SHALL have output port arb_o_err out 1: one-cycle timeout pulse.

Function
REQ-010 SHALL hold one request slot per port; while a port's slot is empty, a cycle with cyc&&stb SHALL latch we, rd, be, addr and wdata into the slot at the clock edge.
REQ-011 SHALL drive arb_o_stall{p} combinationally equal to slot_valid{p}; stb while the slot is full SHALL be ignored and SHALL NOT overwrite the slot.
REQ-012 SHALL treat a request with we=1 and rd=1 as a store; a request with we=0 and rd=0 SHALL complete as a load.
REQ-013 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-014 In IDLE with one valid slot, SHALL grant that port; with both valid, SHALL grant the port not equal to last_grant (round-robin); SHALL register owner and move to ISSUE.
REQ-015 In ISSUE, SHALL drive arb_o_cyc=1 and arb_o_stb=1, plus arb_o_we or arb_o_rd, arb_o_be and the slot data; addr SHALL go on arb_o_store_addr for a store or arb_o_load_addr for a load, with the unused address at 0.
REQ-016 In ISSUE with arb_i_stall=1, SHALL remain in ISSUE with outputs unchanged; with arb_i_stall=0, SHALL go to WAIT.
REQ-017 In WAIT, SHALL drive arb_o_cyc=1 and arb_o_stb=0 with all other memory outputs 0.
REQ-018 On arb_i_ack=1 in ISSUE or WAIT, SHALL register arb_i_rdata into arb_o_rdata{owner}, pulse arb_o_ack{owner} for one cycle, clear the owner's slot, set last_grant=owner and return to IDLE.
REQ-019 arb_o_rdata{p} SHALL hold its value until that port's next completion; a store completion SHALL also load arb_i_rdata.
REQ-020 SHALL count WAIT cycles; at TIMEOUT cycles with no ack, SHALL pulse arb_o_ack{owner} and arb_o_err, set arb_o_rdata{owner}=0, clear the slot and go to IDLE; the counter SHALL clear on leaving WAIT.
REQ-021 SHALL ignore arb_i_ack in IDLE.
REQ-022 arb_i_flush0 SHALL clear slot 0 if it is not owned. If port 0 owns the bus, the transaction SHALL complete on the bus with arb_o_ack0 suppressed.
REQ-023 SHALL accept a new stb on a port no earlier than the cycle after its completion edge.
REQ-024 Minimum latency: stb in cycle N SHALL give the slot valid at N+1, ISSUE at N+2, and, with ack at N+3, arb_o_ack at N+4.

Reset
REQ-025 On arb_rst=0, asynchronously: state=IDLE, slots empty, last_grant=1, counter=0.
REQ-026 On arb_rst=0, asynchronously: all outputs 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no ack after release.

Verification
REQ-028 Port 0 load addr=5, memory acks 1 cycle after stb with rdata=0xDEADBEEF -> arb_o_ack0 pulses at N+4, arb_o_rdata0=0xDEADBEEF, arb_o_load_addr=5 during ISSUE.
REQ-029 Both ports request in the same cycle from reset -> port 0 is served first (last_grant=1), then port 1; a second simultaneous pair is served 0 then 1 again.
REQ-030 Port 1 store be=4'b1100, wdata=0x12340000, arb_i_stall=1 for 3 cycles -> ISSUE lasts 4 cycles with stable outputs and one arb_o_ack1 pulse.
REQ-031 No ack for 16 WAIT cycles -> arb_o_err and arb_o_ack{owner} pulse together, rdata=0, the other pending port is then issued.
REQ-032 arb_i_flush0 while port 0 is queued behind port 1 -> no port-0 bus cycle and no arb_o_ack0; flush while port 0 is in WAIT -> the bus completes and arb_o_ack0 stays 0.
REQ-033 arb_rst asserted in WAIT, ack arrives after release -> no arb_o_ack pulse and state IDLE.
